// File: rtl/mouse_pkg.sv
// Shared types and helpers for the mouse event tracker and its cursor sprite.
package mouse_pkg;

    typedef enum logic [1:0] {StIdle, StPressed, StDrag} drag_state_t;

    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_MIDDLE = 1;
    localparam int unsigned BTN_RIGHT  = 2;

    typedef logic [11:0] rgb12_t;

    function automatic int unsigned clamp(int unsigned v, int unsigned lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    function automatic int unsigned absdiff(int unsigned a, int unsigned b);
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/mouse_cursor_sprite.sv
// Triangular cursor sprite: hit test against the VGA counters plus a colour register.
module mouse_cursor_sprite
    import mouse_pkg::*;
#(
    parameter int unsigned POS_W       = 10,
    parameter int unsigned CURSOR_SIZE = 8,
    parameter rgb12_t      CURSOR_RGB  = 12'hFFF,
    parameter rgb12_t      PRESS_RGB   = 12'hF80
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [POS_W-1:0] cur_x_i,
    input  logic [POS_W-1:0] cur_y_i,
    input  logic [POS_W-1:0] h_cnt_i,
    input  logic [POS_W-1:0] v_cnt_i,
    input  logic             pressed_i,
    output logic             cursor_en_o,
    output rgb12_t           cursor_rgb_o
);

    logic [POS_W-1:0] dx, dy;
    logic             hit;
    logic             en_q;
    rgb12_t           rgb_q;

    // Pixels left of / above the hotspot wrap to large values and miss.
    assign dx  = h_cnt_i - cur_x_i;
    assign dy  = v_cnt_i - cur_y_i;
    assign hit = (32'(dx) < CURSOR_SIZE) && (32'(dy) < CURSOR_SIZE) && (dx <= dy);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            en_q  <= hit;
            rgb_q <= pressed_i ? PRESS_RGB : CURSOR_RGB;
        end
    end

    assign cursor_en_o  = en_q;
    assign cursor_rgb_o = rgb_q;

endmodule

// File: rtl/mouse_event_tracker.sv
// Mouse event tracker: clamped cursor, per-button edge pulses, left-drag FSM and sprite.
// Define MOUSE_DBLCLICK_EN to build the double-click timer; otherwise dbl_click_p_o is 0.
module mouse_event_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned POS_W       = 10,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned NUM_BTN     = 3,
    parameter int unsigned DRAG_THRESH = 4,
    parameter int unsigned CURSOR_SIZE = 8,
    parameter rgb12_t      CURSOR_RGB  = 12'hFFF,
    parameter rgb12_t      PRESS_RGB   = 12'hF80,
    parameter int unsigned DBL_CYCLES  = 25_000_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [POS_W-1:0]   raw_x_i,
    input  logic [POS_W-1:0]   raw_y_i,
    input  logic [NUM_BTN-1:0] raw_btn_i,
    input  logic               new_event_i,
    input  logic [POS_W-1:0]   h_cnt_i,
    input  logic [POS_W-1:0]   v_cnt_i,
    output logic [POS_W-1:0]   cur_x_o,
    output logic [POS_W-1:0]   cur_y_o,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] press_p_o,
    output logic [NUM_BTN-1:0] release_p_o,
    output logic               click_p_o,
    output logic               dbl_click_p_o,
    output logic               drag_active_o,
    output logic [POS_W-1:0]   anchor_x_o,
    output logic [POS_W-1:0]   anchor_y_o,
    output logic               cursor_en_o,
    output rgb12_t             cursor_rgb_o
);

    logic [POS_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [POS_W-1:0]   anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
    logic [NUM_BTN-1:0] btn_q, btn_d, press_q, press_d, release_q, release_d;
    logic               click_q, click_d;
    drag_state_t        state_q, state_d;
    logic [POS_W-1:0]   new_x, new_y;
    logic               moved;

    assign new_x = POS_W'(clamp(32'(raw_x_i), SCREEN_W));
    assign new_y = POS_W'(clamp(32'(raw_y_i), SCREEN_H));
    assign moved = (absdiff(32'(new_x), 32'(anchor_x_q)) >= DRAG_THRESH) ||
                   (absdiff(32'(new_y), 32'(anchor_y_q)) >= DRAG_THRESH);

    always_comb begin
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        btn_d      = btn_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        state_d    = state_q;
        press_d    = '0;
        release_d  = '0;
        click_d    = 1'b0;
        if (new_event_i) begin
            cur_x_d   = new_x;
            cur_y_d   = new_y;
            btn_d     = raw_btn_i;
            press_d   = raw_btn_i & ~btn_q;
            release_d = ~raw_btn_i & btn_q;
            case (state_q)
                StIdle: begin
                    // A press never jumps straight to drag, even with a big move.
                    if (press_d[BTN_LEFT]) begin
                        state_d    = StPressed;
                        anchor_x_d = new_x;
                        anchor_y_d = new_y;
                    end
                end
                StPressed: begin
                    if (!raw_btn_i[BTN_LEFT]) begin
                        state_d = StIdle;
                        click_d = 1'b1;
                    end else if (moved) begin
                        state_d = StDrag;
                    end
                end
                StDrag: begin
                    if (!raw_btn_i[BTN_LEFT]) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_x_q    <= POS_W'(SCREEN_W / 2);
            cur_y_q    <= POS_W'(SCREEN_H / 2);
            anchor_x_q <= '0;
            anchor_y_q <= '0;
            btn_q      <= '0;
            press_q    <= '0;
            release_q  <= '0;
            click_q    <= 1'b0;
            state_q    <= StIdle;
        end else begin
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            state_q    <= state_d;
        end
    end

`ifdef MOUSE_DBLCLICK_EN
    localparam int unsigned TMR_W = $clog2(DBL_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dbl_q, dbl_d;

    // click_d is decided one cycle before click_p shows; a timer above 1 now is still
    // non-zero in the cycle the click pulse is visible.
    always_comb begin
        dbl_d   = click_d && (timer_q > TMR_W'(1));
        timer_d = timer_q;
        if (click_d) begin
            timer_d = dbl_d ? '0 : TMR_W'(DBL_CYCLES);
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
            dbl_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            dbl_q   <= dbl_d;
        end
    end

    assign dbl_click_p_o = dbl_q;
`else
    assign dbl_click_p_o = 1'b0;
`endif

    mouse_cursor_sprite #(
        .POS_W      (POS_W),
        .CURSOR_SIZE(CURSOR_SIZE),
        .CURSOR_RGB (CURSOR_RGB),
        .PRESS_RGB  (PRESS_RGB)
    ) u_sprite (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cur_x_i     (cur_x_q),
        .cur_y_i     (cur_y_q),
        .h_cnt_i     (h_cnt_i),
        .v_cnt_i     (v_cnt_i),
        .pressed_i   (btn_q[BTN_LEFT]),
        .cursor_en_o (cursor_en_o),
        .cursor_rgb_o(cursor_rgb_o)
    );

    assign cur_x_o       = cur_x_q;
    assign cur_y_o       = cur_y_q;
    assign btn_level_o   = btn_q;
    assign press_p_o     = press_q;
    assign release_p_o   = release_q;
    assign click_p_o     = click_q;
    assign drag_active_o = (state_q == StDrag);
    assign anchor_x_o    = anchor_x_q;
    assign anchor_y_o    = anchor_y_q;

endmodule

// File: tb/tb_mouse_event_tracker.sv
// Bench for mouse_event_tracker: directed table, double-click sequences, random vs model.
module tb_mouse_event_tracker;

    localparam int DBL = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_x = '0, raw_y = '0, h_cnt = '0, v_cnt = '0;
    logic [2:0] raw_btn = '0;
    logic       new_event = 1'b0;

    logic [9:0]  cur_x, cur_y, anchor_x, anchor_y;
    logic [2:0]  btn_level, press_p, release_p;
    logic        click_p, dbl_click_p, drag_active, cursor_en;
    logic [11:0] cursor_rgb;

    always #5 clk = ~clk;

    mouse_event_tracker #(
        .DBL_CYCLES(DBL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .raw_x_i      (raw_x),
        .raw_y_i      (raw_y),
        .raw_btn_i    (raw_btn),
        .new_event_i  (new_event),
        .h_cnt_i      (h_cnt),
        .v_cnt_i      (v_cnt),
        .cur_x_o      (cur_x),
        .cur_y_o      (cur_y),
        .btn_level_o  (btn_level),
        .press_p_o    (press_p),
        .release_p_o  (release_p),
        .click_p_o    (click_p),
        .dbl_click_p_o(dbl_click_p),
        .drag_active_o(drag_active),
        .anchor_x_o   (anchor_x),
        .anchor_y_o   (anchor_y),
        .cursor_en_o  (cursor_en),
        .cursor_rgb_o (cursor_rgb)
    );

`ifdef MOUSE_DBLCLICK_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: what the outputs should read after the latest edge.
    int          m_x, m_y, m_ax, m_ay, m_last;
    logic [2:0]  m_btn, m_press, m_rel;
    bit          m_click, m_dbl, m_held, m_drag, m_en;
    logic [11:0] m_rgb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model(input bit r, input bit ev, input int rx, input int ry,
                         input logic [2:0] rb, input int h, input int v);
        int nx, ny, dx, dy;
        if (r) begin
            m_x = 320; m_y = 240; m_ax = 0; m_ay = 0; m_last = -1;
            m_btn = 0; m_press = 0; m_rel = 0;
            m_click = 0; m_dbl = 0; m_held = 0; m_drag = 0; m_en = 0; m_rgb = 0;
            return;
        end
        dx = h - m_x;
        dy = v - m_y;
        m_en  = dx >= 0 && dy >= 0 && dx < 8 && dy < 8 && dx <= dy;
        m_rgb = m_btn[0] ? 12'hF80 : 12'hFFF;
        m_press = 0; m_rel = 0; m_click = 0; m_dbl = 0;
        if (ev) begin
            nx = (rx > 639) ? 639 : rx;
            ny = (ry > 479) ? 479 : ry;
            if (m_held) begin
                if (!rb[0]) begin
                    m_held = 0; m_click = 1;
                end else if (iabs(nx - m_ax) >= 4 || iabs(ny - m_ay) >= 4) begin
                    m_held = 0; m_drag = 1;
                end
            end else if (m_drag) begin
                if (!rb[0]) m_drag = 0;
            end else if (rb[0] && !m_btn[0]) begin
                m_held = 1; m_ax = nx; m_ay = ny;
            end
            m_press = rb & ~m_btn;
            m_rel   = ~rb & m_btn;
            m_btn   = rb;
            m_x = nx;
            m_y = ny;
            if (m_click && DBL_EN) begin
                if (m_last >= 0 && cyc - m_last < DBL) begin
                    m_dbl = 1; m_last = -1;
                end else begin
                    m_last = cyc;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit ev, input int rx, input int ry,
                        input logic [2:0] rb, input int h, input int v);
        rst = r; new_event = ev; raw_x = 10'(rx); raw_y = 10'(ry); raw_btn = rb;
        h_cnt = 10'(h); v_cnt = 10'(v);
        @(posedge clk);
        cyc++;
        model(r, ev, rx, ry, rb, h, v);
        #1;
        chk("m_cur_x", 32'(cur_x), m_x);
        chk("m_cur_y", 32'(cur_y), m_y);
        chk("m_btn_level", 32'(btn_level), 32'(m_btn));
        chk("m_press_p", 32'(press_p), 32'(m_press));
        chk("m_release_p", 32'(release_p), 32'(m_rel));
        chk("m_click_p", 32'(click_p), 32'(m_click));
        chk("m_dbl_click_p", 32'(dbl_click_p), 32'(m_dbl));
        chk("m_drag_active", 32'(drag_active), 32'(m_drag));
        chk("m_anchor_x", 32'(anchor_x), m_ax);
        chk("m_anchor_y", 32'(anchor_y), m_ay);
        chk("m_cursor_en", 32'(cursor_en), 32'(m_en));
        if (m_en) chk("m_cursor_rgb", 32'(cursor_rgb), 32'(m_rgb));
    endtask

    typedef struct {
        bit ev; int rx; int ry; logic [2:0] rb; int h; int v;
        int x; int y; bit p; bit rl; bit clk; bit dbl; bit drag; int ax; int ay;
        bit en; logic [11:0] rgb;
    } vec_t;

    function automatic vec_t mk(bit ev, int rx, int ry, logic [2:0] rb, int h, int v,
                                int x, int y, bit p, bit rl, bit ck, bit dbl, bit drag,
                                int ax, int ay, bit en, logic [11:0] rgb);
        vec_t t;
        t.ev = ev; t.rx = rx; t.ry = ry; t.rb = rb; t.h = h; t.v = v;
        t.x = x; t.y = y; t.p = p; t.rl = rl; t.clk = ck; t.dbl = dbl; t.drag = drag;
        t.ax = ax; t.ay = ay; t.en = en; t.rgb = rgb;
        return t;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'b000, 0, 0);
    endtask

    task automatic do_click(input bit exp_dbl, input string nm);
        step(0, 1, 200, 200, 3'b001, 0, 0);
        step(0, 1, 201, 200, 3'b000, 0, 0);
        chk({nm, "_click"}, 32'(click_p), 32'd1);
        chk({nm, "_dbl"}, 32'(dbl_click_p), 32'(exp_dbl && DBL_EN));
    endtask

    vec_t tab[17];

    initial begin
        tab[0]  = mk(1, 700, 1023, 3'b000,  0,  0, 639, 479, 0, 0, 0, 0, 0,   0,   0, 0, 12'h000);
        tab[1]  = mk(1, 100,  100, 3'b001,  0,  0, 100, 100, 1, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[2]  = mk(0, 999,  999, 3'b000,  0,  0, 100, 100, 0, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[3]  = mk(1, 102,  101, 3'b000,  0,  0, 102, 101, 0, 1, 1, 0, 0, 100, 100, 0, 12'h000);
        tab[4]  = mk(1, 100,  100, 3'b001,  0,  0, 100, 100, 1, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[5]  = mk(1, 103,  100, 3'b001,  0,  0, 103, 100, 0, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[6]  = mk(1, 110,  100, 3'b001,  0,  0, 110, 100, 0, 0, 0, 0, 1, 100, 100, 0, 12'h000);
        tab[7]  = mk(0,   0,    0, 3'b000,  0,  0, 110, 100, 0, 0, 0, 0, 1, 100, 100, 0, 12'h000);
        tab[8]  = mk(1, 110,  100, 3'b000,  0,  0, 110, 100, 0, 1, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[9]  = mk(1,  10,   10, 3'b000,  0,  0,  10,  10, 0, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[10] = mk(0,   0,    0, 3'b000, 12, 15,  10,  10, 0, 0, 0, 0, 0, 100, 100, 1, 12'hFFF);
        tab[11] = mk(0,   0,    0, 3'b000, 15, 12,  10,  10, 0, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[12] = mk(0,   0,    0, 3'b000,  9, 10,  10,  10, 0, 0, 0, 0, 0, 100, 100, 0, 12'h000);
        tab[13] = mk(1,  10,   10, 3'b001, 10, 10,  10,  10, 1, 0, 0, 0, 0,  10,  10, 1, 12'hFFF);
        tab[14] = mk(0,   0,    0, 3'b000, 10, 17,  10,  10, 0, 0, 0, 0, 0,  10,  10, 1, 12'hF80);
        tab[15] = mk(0,   0,    0, 3'b000, 10, 18,  10,  10, 0, 0, 0, 0, 0,  10,  10, 0, 12'h000);
        tab[16] = mk(1,  10,   10, 3'b000,  0,  0,  10,  10, 0, 1, 1, 1, 0,  10,  10, 0, 12'h000);

        step(1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 0, 0, 0, 3'b000, 0, 0);
        chk("rst_cur_x", 32'(cur_x), 32'd320);
        chk("rst_cur_y", 32'(cur_y), 32'd240);
        chk("rst_pulses", 32'({press_p, release_p, click_p, dbl_click_p}), 32'd0);
        chk("rst_drag", 32'(drag_active), 32'd0);

        foreach (tab[i]) begin
            step(0, tab[i].ev, tab[i].rx, tab[i].ry, tab[i].rb, tab[i].h, tab[i].v);
            chk($sformatf("tab%0d_x", i), 32'(cur_x), tab[i].x);
            chk($sformatf("tab%0d_y", i), 32'(cur_y), tab[i].y);
            chk($sformatf("tab%0d_press", i), 32'(press_p[0]), 32'(tab[i].p));
            chk($sformatf("tab%0d_release", i), 32'(release_p[0]), 32'(tab[i].rl));
            chk($sformatf("tab%0d_click", i), 32'(click_p), 32'(tab[i].clk));
            chk($sformatf("tab%0d_dbl", i), 32'(dbl_click_p), 32'(tab[i].dbl && DBL_EN));
            chk($sformatf("tab%0d_drag", i), 32'(drag_active), 32'(tab[i].drag));
            chk($sformatf("tab%0d_anchor", i), 32'({anchor_x, anchor_y}),
                32'({10'(tab[i].ax), 10'(tab[i].ay)}));
            chk($sformatf("tab%0d_en", i), 32'(cursor_en), 32'(tab[i].en));
            if (tab[i].en) chk($sformatf("tab%0d_rgb", i), 32'(cursor_rgb), 32'(tab[i].rgb));
        end

        idle(120);
        do_click(0, "dbl_first");
        idle(48);
        do_click(1, "dbl_50");
        idle(10);
        do_click(0, "dbl_triple");
        idle(120);
        do_click(0, "gap_first");
        idle(98);
        do_click(0, "dbl_100");

        step(1, 1, 5, 5, 3'b111, 0, 0);
        chk("rst_prio_x", 32'(cur_x), 32'd320);
        chk("rst_prio_btn", 32'(btn_level), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit   r, ev;
            int   rx, ry, h, v;
            r  = ($urandom_range(0, 299) == 0);
            ev = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rx = m_x + $urandom_range(0, 12) - 6;
                ry = m_y + $urandom_range(0, 12) - 6;
                if (rx < 0) rx = 0;
                if (ry < 0) ry = 0;
            end else begin
                rx = $urandom_range(0, 1023);
                ry = $urandom_range(0, 1023);
            end
            h = m_x + $urandom_range(0, 11) - 2;
            v = m_y + $urandom_range(0, 11) - 2;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            step(r, ev, rx, ry, 3'($urandom_range(0, 7)), h, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
